// File: rtl/uart_rx_frame_if.sv
// Receive-side UART bundle: serial line in, received byte and per-frame status out.
// The slave side is the frame engine; the master side drives rx and consumes results.
interface uart_rx_frame_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 busy;

   modport master (
      output rx,
      input  data_out,
      input  data_valid,
      input  parity_err,
      input  frame_err,
      input  busy
   );

   modport slave (
      input  rx,
      output data_out,
      output data_valid,
      output parity_err,
      output frame_err,
      output busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: synchronises rx, samples each bit at mid-bit, deserialises
// LSB first, checks optional parity and the stop bit, and reports one valid pulse per frame.
module uart_rx_frame #(
   parameter int unsigned BAUD_DIV   = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input logic            clk,
   input logic            rst,
   uart_rx_frame_if.slave bus
);

   localparam int unsigned CntW = $clog2(BAUD_DIV);
   localparam int unsigned BitW = $clog2(DATA_BITS);
   localparam logic [CntW-1:0] HalfLoad = CntW'(BAUD_DIV / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(BAUD_DIV - 1);
   localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS - 1);
   localparam logic ParEn  = (PARITY_EN != 0);
   localparam logic ParOdd = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_e;

   state_e state_q, state_d;

   logic [1:0]           rx_sync_q, rx_sync_d;
   logic [CntW-1:0]      baud_cnt_q, baud_cnt_d;
   logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 parity_err_q, parity_err_d;
   logic                 frame_err_q, frame_err_d;

   logic rx_s;
   logic tick;
   logic last_bit;

   assign rx_s     = rx_sync_q[1];
   assign tick     = (baud_cnt_q == '0);
   assign last_bit = (bit_cnt_q == LastBit);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (!rx_s) state_d = StStart;
         StStart:  if (tick) state_d = rx_s ? StIdle : StData;
         StData:   if (tick && last_bit) state_d = ParEn ? StParity : StStop;
         StParity: if (tick) state_d = StStop;
         StStop:   if (tick) state_d = rx_s ? StIdle : StBreak;
         StBreak:  if (rx_s) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Synchroniser, baud/bit counters and shift register
   always_comb begin
      rx_sync_d  = {rx_sync_q[0], bus.rx};
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      unique case (state_q)
         StIdle: begin
            if (!rx_s) baud_cnt_d = HalfLoad;
         end
         StStart: begin
            if (tick) begin
               baud_cnt_d = FullLoad;
               bit_cnt_d  = '0;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         StData: begin
            if (tick) begin
               baud_cnt_d = FullLoad;
               shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         StParity: begin
            if (tick) begin
               baud_cnt_d = FullLoad;
               par_d      = rx_s;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end
         StStop: begin
            if (!tick) baud_cnt_d = baud_cnt_q - 1'b1;
         end
         StBreak: begin
            baud_cnt_d = baud_cnt_q;
         end
         default: begin
            baud_cnt_d = '0;
         end
      endcase
   end

   // Outputs update only on the cycle after the stop sample
   always_comb begin
      data_valid_d = 1'b0;
      data_out_d   = data_out_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      if ((state_q == StStop) && tick) begin
         data_valid_d = 1'b1;
         data_out_d   = shift_q;
         parity_err_d = ParEn & ((^shift_q ^ par_q) != ParOdd);
         frame_err_d  = ~rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_sync_q    <= 2'b11;
         baud_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_sync_q    <= rx_sync_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.parity_err = parity_err_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an even-parity and an odd-parity receiver share one rx line.
module tb_uart_rx_frame;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_line = 1'b1;

   int checks = 0;
   int errors = 0;

   uart_rx_frame_if #(.DATA_BITS(8)) if_even ();
   uart_rx_frame_if #(.DATA_BITS(8)) if_odd ();

   assign if_even.rx = rx_line;
   assign if_odd.rx  = rx_line;

   uart_rx_frame #(
      .BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)
   ) u_even (
      .clk(clk), .rst(rst), .bus(if_even)
   );

   uart_rx_frame #(
      .BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)
   ) u_odd (
      .clk(clk), .rst(rst), .bus(if_odd)
   );

   always #5 clk = ~clk;

   int unsigned ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   // Pulse monitor: records every data_valid with its data and flags
   int unsigned pulse_cnt = 0;
   int unsigned odd_pulse_cnt = 0;
   int unsigned last_pulse_ncyc = 0;
   logic [9:0]  pulse_q[$];
   always @(negedge clk) begin
      if (if_even.data_valid) begin
         pulse_cnt++;
         last_pulse_ncyc = ncyc;
         pulse_q.push_back({if_even.parity_err, if_even.frame_err, if_even.data_out});
      end
      if (if_odd.data_valid) odd_pulse_cnt++;
   end

   int unsigned frame_start = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic lvl, input int n);
      rx_line = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
      frame_start = ncyc;
      hold(1'b0, 16);
      for (int i = 0; i < 8; i++) hold(d[i], 16);
      hold(p, 16);
      hold(stop, 16);
   endtask

   int unsigned p0;
   int unsigned q0;
   logic [9:0]  ent;

   initial begin
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("rst_data_out", if_even.data_out, 0);
      check("rst_data_valid", if_even.data_valid, 0);
      check("rst_parity_err", if_even.parity_err, 0);
      check("rst_frame_err", if_even.frame_err, 0);
      check("rst_busy", if_even.busy, 0);
      rst = 1'b0;
      hold(1'b1, 10);

      // 1: clean frame, latency from rx falling
      p0 = pulse_cnt;
      send_frame(8'h55, 1'b0, 1'b1);
      hold(1'b1, 10);
      check("t1_pulses", pulse_cnt - p0, 1);
      check("t1_latency", last_pulse_ncyc - frame_start, 171);
      check("t1_data", if_even.data_out, 8'h55);
      check("t1_parity_err", if_even.parity_err, 0);
      check("t1_frame_err", if_even.frame_err, 0);
      check("t1_valid_low", if_even.data_valid, 0);

      // 2: wrong even parity; the odd receiver accepts it
      p0 = pulse_cnt;
      q0 = odd_pulse_cnt;
      send_frame(8'hA7, 1'b0, 1'b1);
      hold(1'b1, 10);
      check("t2_pulses", pulse_cnt - p0, 1);
      check("t2_data", if_even.data_out, 8'hA7);
      check("t2_parity_err", if_even.parity_err, 1);
      check("t2_frame_err", if_even.frame_err, 0);
      check("t2_odd_pulses", odd_pulse_cnt - q0, 1);
      check("t2_odd_data", if_odd.data_out, 8'hA7);
      check("t2_odd_parity_err", if_odd.parity_err, 0);

      // 3: stop bit low, then line held low for 40 bit times
      p0 = pulse_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      hold(1'b0, 640);
      check("t3_pulses", pulse_cnt - p0, 1);
      check("t3_data", if_even.data_out, 8'h3C);
      check("t3_frame_err", if_even.frame_err, 1);
      check("t3_parity_err", if_even.parity_err, 0);
      check("t3_busy_held", if_even.busy, 1);
      hold(1'b1, 4);
      check("t3_busy_released", if_even.busy, 0);
      hold(1'b1, 40);
      check("t3_no_second", pulse_cnt - p0, 1);

      // 4: 5-cycle glitch while idle
      p0 = pulse_cnt;
      hold(1'b0, 5);
      hold(1'b1, 5);
      check("t4_busy_at_tick", if_even.busy, 1);
      hold(1'b1, 1);
      check("t4_busy_after", if_even.busy, 0);
      hold(1'b1, 200);
      check("t4_pulses", pulse_cnt - p0, 0);
      check("t4_data", if_even.data_out, 8'h3C);
      check("t4_frame_err", if_even.frame_err, 1);
      check("t4_parity_err", if_even.parity_err, 0);

      // 5: back-to-back frames
      pulse_q.delete();
      send_frame(8'h01, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_frame(8'h80, 1'b1, 1'b1);
      hold(1'b1, 20);
      check("t5_pulses", pulse_q.size(), 3);
      if (pulse_q.size() == 3) begin
         ent = pulse_q.pop_front();
         check("t5_frame0", ent, {2'b00, 8'h01});
         ent = pulse_q.pop_front();
         check("t5_frame1", ent, {2'b00, 8'hFF});
         ent = pulse_q.pop_front();
         check("t5_frame2", ent, {2'b00, 8'h80});
      end

      // 6: reset in the middle of data bit 4, then a clean frame
      p0 = pulse_cnt;
      hold(1'b0, 16);
      hold(1'b0, 16);
      hold(1'b1, 16);
      hold(1'b0, 16);
      hold(1'b1, 16);
      hold(1'b1, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_rst_data", if_even.data_out, 0);
      check("t6_rst_valid", if_even.data_valid, 0);
      check("t6_rst_busy", if_even.busy, 0);
      check("t6_rst_frame_err", if_even.frame_err, 0);
      hold(1'b1, 40);
      check("t6_no_pulse", pulse_cnt - p0, 0);
      send_frame(8'h96, 1'b0, 1'b1);
      hold(1'b1, 20);
      check("t6_pulses", pulse_cnt - p0, 1);
      check("t6_data", if_even.data_out, 8'h96);
      check("t6_parity_err", if_even.parity_err, 0);
      check("t6_frame_err", if_even.frame_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
